// File: rtl/arm_bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter, per-entry state, counter update rule.
package arm_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_e;

    // Per-entry state; tag and target live beside it at their parameterised widths.
    typedef struct packed {
        logic    valid;
        bp_ctr_e ctr;
    } bp_entry_t;

    function automatic bp_ctr_e ctr_update(input bp_ctr_e ctr, input logic taken);
        bp_ctr_e nxt;
        nxt = ctr;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_SNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/arm_bp_table.sv
// Direct-mapped predictor table: one lookup read port, one read-modify-write update port.
module arm_bp_table
    import arm_bp_pkg::*;
#(
    parameter int unsigned Entries = 16,
    parameter int unsigned IdxW    = 4,
    parameter int unsigned TagW    = 26,
    parameter int unsigned DataW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IdxW-1:0]  rd_idx,
    output logic             rd_valid,
    output bp_ctr_e          rd_ctr,
    output logic [TagW-1:0]  rd_tag,
    output logic [DataW-1:0] rd_target,
    input  logic             wr_en,
    input  logic [IdxW-1:0]  wr_idx,
    input  logic [TagW-1:0]  wr_tag,
    input  logic [DataW-1:0] wr_target,
    input  logic             wr_taken
);

    bp_entry_t        meta_q   [Entries];
    logic [TagW-1:0]  tag_q    [Entries];
    logic [DataW-1:0] target_q [Entries];
    logic             wr_hit;

    assign rd_valid  = meta_q[rd_idx].valid;
    assign rd_ctr    = meta_q[rd_idx].ctr;
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    assign wr_hit = meta_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);

    // Flush beats a same-cycle update; a not-taken miss leaves the entry alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                meta_q[IdxW'(i)]   <= '{valid: 1'b0, ctr: CTR_SNT};
                tag_q[IdxW'(i)]    <= '0;
                target_q[IdxW'(i)] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                meta_q[IdxW'(i)].valid <= 1'b0;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                meta_q[wr_idx].ctr <= ctr_update(meta_q[wr_idx].ctr, wr_taken);
                if (wr_taken) begin
                    target_q[wr_idx] <= wr_target;
                end
            end else if (wr_taken) begin
                meta_q[wr_idx]   <= '{valid: 1'b1, ctr: CTR_WT};
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/arm_branch_predictor.sv
// Branch target buffer with 2-bit direction counters, execute-stage mispredict detection and tally.
module arm_branch_predictor
    import arm_bp_pkg::*;
#(
    parameter int unsigned BusWidth   = 32,
    parameter int unsigned Entries    = 16,
    parameter int unsigned CountWidth = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic [BusWidth-1:0]   i_Fetch_PC,
    output logic                  o_Predict_Taken,
    output logic [BusWidth-1:0]   o_Predict_Target,
    input  logic                  i_Update_Valid,
    input  logic [BusWidth-1:0]   i_Update_PC,
    input  logic [BusWidth-1:0]   i_Update_Target,
    input  logic                  i_Update_Taken,
    input  logic                  i_Update_Pred_Taken,
    input  logic [BusWidth-1:0]   i_Update_Pred_Target,
    input  logic                  i_Flush_All,
    output logic                  o_Mispredict,
    output logic [BusWidth-1:0]   o_Redirect_PC,
    output logic [CountWidth-1:0] o_Mispredict_Count
);

    localparam int unsigned IdxW = $clog2(Entries);
    localparam int unsigned TagW = BusWidth - IdxW - 2;

    logic [IdxW-1:0]     fetch_idx;
    logic [TagW-1:0]     fetch_tag;
    logic [IdxW-1:0]     upd_idx;
    logic [TagW-1:0]     upd_tag;
    logic                rd_valid;
    bp_ctr_e             rd_ctr;
    logic [TagW-1:0]     rd_tag;
    logic [BusWidth-1:0] rd_target;
    logic                hit;
    logic                unused_fetch_lsbs;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign fetch_idx         = i_Fetch_PC[IdxW+1:2];
    assign fetch_tag         = i_Fetch_PC[BusWidth-1:IdxW+2];
    assign upd_idx           = i_Update_PC[IdxW+1:2];
    assign upd_tag           = i_Update_PC[BusWidth-1:IdxW+2];
    assign unused_fetch_lsbs = ^i_Fetch_PC[1:0];

    arm_bp_table #(
        .Entries (Entries),
        .IdxW    (IdxW),
        .TagW    (TagW),
        .DataW   (BusWidth)
    ) u_table (
        .clk       (i_CLK),
        .rst       (i_RESET),
        .flush     (i_Flush_All),
        .rd_idx    (fetch_idx),
        .rd_valid  (rd_valid),
        .rd_ctr    (rd_ctr),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (i_Update_Valid),
        .wr_idx    (upd_idx),
        .wr_tag    (upd_tag),
        .wr_target (i_Update_Target),
        .wr_taken  (i_Update_Taken)
    );

    assign hit              = rd_valid && (rd_tag == fetch_tag);
    assign o_Predict_Taken  = hit && (rd_ctr inside {CTR_WT, CTR_ST});
    assign o_Predict_Target = hit ? rd_target : '0;

    assign o_Mispredict  = i_Update_Valid &&
                           ((i_Update_Pred_Taken != i_Update_Taken) ||
                            (i_Update_Taken && i_Update_Pred_Taken &&
                             (i_Update_Pred_Target != i_Update_Target)));
    assign o_Redirect_PC = i_Update_Taken ? i_Update_Target : i_Update_PC + BusWidth'(4);

    // Saturating tally; flushes do not touch it.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            o_Mispredict_Count <= '0;
        end else if (o_Mispredict && (o_Mispredict_Count != '1)) begin
            o_Mispredict_Count <= o_Mispredict_Count + CountWidth'(1);
        end
    end

endmodule

// File: tb/tb_arm_branch_predictor.sv
// Scoreboard bench for arm_branch_predictor (BusWidth=32, Entries=16, CountWidth=4).
module tb_arm_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  mis_count;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        rst;
        logic [31:0] fetch;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        ut;
        logic        upt;
        logic [31:0] uptgt;
        logic        flush;
    } stim_t;

    typedef struct {
        string       name;
        bit          et;
        logic [31:0] etgt;
        bit          cm;
        bit          em;
        logic [31:0] eredir;
        logic [3:0]  ecnt;
    } exp_t;

    exp_t sb[$];

    arm_branch_predictor #(
        .BusWidth   (32),
        .Entries    (16),
        .CountWidth (4)
    ) dut (
        .i_CLK                (clk),
        .i_RESET              (rst),
        .i_Fetch_PC           (fetch_pc),
        .o_Predict_Taken      (pred_taken),
        .o_Predict_Target     (pred_target),
        .i_Update_Valid       (upd_valid),
        .i_Update_PC          (upd_pc),
        .i_Update_Target      (upd_target),
        .i_Update_Taken       (upd_taken),
        .i_Update_Pred_Taken  (upd_pred_taken),
        .i_Update_Pred_Target (upd_pred_target),
        .i_Flush_All          (flush_all),
        .o_Mispredict         (mispredict),
        .o_Redirect_PC        (redirect_pc),
        .o_Mispredict_Count   (mis_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t S(input logic [31:0] fetch, input logic uv = 1'b0,
                                input logic [31:0] upc = 32'h0, input logic [31:0] utgt = 32'h0,
                                input logic ut = 1'b0, input logic upt = 1'b0,
                                input logic [31:0] uptgt = 32'h0, input logic flush = 1'b0,
                                input logic r = 1'b0);
        stim_t s;
        s.rst = r; s.fetch = fetch; s.uv = uv; s.upc = upc; s.utgt = utgt;
        s.ut = ut; s.upt = upt; s.uptgt = uptgt; s.flush = flush;
        return s;
    endfunction

    function automatic exp_t E(input string name, input bit et, input logic [31:0] etgt,
                               input bit cm, input bit em, input logic [31:0] eredir,
                               input int cnt);
        exp_t e;
        e.name = name; e.et = et; e.etgt = etgt; e.cm = cm; e.em = em;
        e.eredir = eredir; e.ecnt = 4'(cnt);
        return e;
    endfunction

    task automatic issue(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst = s.rst; fetch_pc = s.fetch; upd_valid = s.uv; upd_pc = s.upc;
        upd_target = s.utgt; upd_taken = s.ut; upd_pred_taken = s.upt;
        upd_pred_target = s.uptgt; flush_all = s.flush;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: outputs are presented every cycle; compare each pending expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, "/taken"},  32'(pred_taken),  32'(e.et));
                chk({e.name, "/target"}, pred_target,      e.etgt);
                if (e.cm) begin
                    chk({e.name, "/mispredict"}, 32'(mispredict), 32'(e.em));
                    chk({e.name, "/redirect"},   redirect_pc,     e.eredir);
                end
                chk({e.name, "/count"}, 32'(mis_count), 32'(e.ecnt));
            end
        end
    end

    initial begin
        rst = 1'b0; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        upd_taken = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush_all = 1'b0;

        issue(S(32'h100, 0, 0, 0, 0, 0, 0, 0, 1),              E("reset_lookup", 0, 0, 1, 0, 32'h4, 0));
        issue(S(32'h100, 1, 32'h100, 32'h200, 1, 0, 0),        E("alloc_same_cycle", 0, 0, 1, 1, 32'h200, 0));
        issue(S(32'h100),                                      E("alloc_hit", 1, 32'h200, 1, 0, 32'h4, 1));
        issue(S(32'h100, 1, 32'h100, 32'h200, 0, 1, 32'h200),  E("not_taken_1", 1, 32'h200, 1, 1, 32'h104, 1));
        issue(S(32'h100, 1, 32'h100, 32'h200, 0, 0, 0),        E("not_taken_2", 0, 32'h200, 1, 0, 32'h104, 2));
        issue(S(32'h100),                                      E("strong_nt", 0, 32'h200, 1, 0, 32'h4, 2));
        issue(S(32'h140, 1, 32'h140, 32'h300, 1, 0, 0),        E("alias_miss", 0, 0, 1, 1, 32'h300, 2));
        issue(S(32'h100),                                      E("alias_evict", 0, 0, 1, 0, 32'h4, 3));
        issue(S(32'h140, 1, 32'h140, 32'h300, 1, 1, 32'h300),  E("match_target", 1, 32'h300, 1, 0, 32'h300, 3));
        issue(S(32'h140, 1, 32'h140, 32'h340, 1, 1, 32'h300),  E("wrong_target", 1, 32'h300, 1, 1, 32'h340, 3));
        issue(S(32'h140, 1, 32'h180, 32'h0, 0, 0, 0),          E("new_target", 1, 32'h340, 1, 0, 32'h184, 4));
        issue(S(32'h140),                                      E("nt_miss_noalloc", 1, 32'h340, 1, 0, 32'h4, 4));
        issue(S(32'h180, 1, 32'h180, 32'h400, 1, 0, 0, 1),     E("flush_same_cycle", 0, 0, 1, 1, 32'h400, 4));
        issue(S(32'h180),                                      E("flush_180", 0, 0, 1, 0, 32'h4, 5));
        issue(S(32'h140),                                      E("flush_140", 0, 0, 1, 0, 32'h4, 5));
        issue(S(32'h1004, 1, 32'h1004, 32'h2000, 1, 0, 0),     E("idx1_alloc", 0, 0, 1, 1, 32'h2000, 5));
        issue(S(32'h1004),                                     E("idx1_hit", 1, 32'h2000, 1, 0, 32'h4, 6));
        issue(S(32'h1006, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0),   E("lsb_ignore_wrap", 1, 32'h2000, 1, 0, 32'h0, 6));
        issue(S(32'h1004, 1, 32'h100, 32'h500, 1, 0, 0, 0, 1), E("reset_mid_update", 0, 0, 0, 0, 32'h0, 0));
        issue(S(32'h100),                                      E("post_reset_100", 0, 0, 1, 0, 32'h4, 0));
        issue(S(32'h1004),                                     E("post_reset_1004", 0, 0, 1, 0, 32'h4, 0));
        for (int i = 0; i < 20; i++) begin
            issue(S(32'h0, 1, 32'h200, 32'h0, 0, 1, 0),
                  E($sformatf("saturate_%0d", i), 0, 0, 1, 1, 32'h204, (i > 15) ? 15 : i));
        end
        issue(S(32'h0),                                        E("saturate_hold", 0, 0, 1, 0, 32'h4, 15));

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
